// File: rtl/muldiv_ctrl_if.sv
// Interface between the EX stage and the multiply/divide sequencer.
//   master (EX side): drives start/op/src_a/src_b/annul, receives stall and HI/LO write.
//   slave  (muldiv_ctrl): the reverse.
//   start    : muldiv op presented this cycle      op       : 00 mult 01 multu 10 div 11 divu
//   src_a/b  : rs / rt operands                    annul    : flush the in-flight op
//   stallreq : hold pipeline                       busy     : sequencer not idle
//   done     : one-cycle result pulse              hi_we/lo_we, hi_wdata/lo_wdata : HI/LO write
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             annul;
    logic             stallreq;
    logic             busy;
    logic             done;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;

    modport master (
        output start, op, src_a, src_b, annul,
        input  stallreq, busy, done, hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport slave (
        input  start, op, src_a, src_b, annul,
        output stallreq, busy, done, hi_we, lo_we, hi_wdata, lo_wdata
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage. One 2*WIDTH-bit
// adder/subtractor is shared by shift-add multiply, restoring divide and the
// final sign fix-up. Results leave as a one-cycle HI/LO write.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : muldiv_ctrl_if.slave (operands in, stall/busy/HI-LO write out)
module muldiv_ctrl #(
    parameter int WIDTH     = 32,
    parameter int FAST_ZERO = 1
) (
    input logic          clk,
    input logic          resetn,
    muldiv_ctrl_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_FIX  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]         state;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    // acc holds {hi, lo}: product for mult, {remainder, quotient} for div.
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               neg_r;
    logic [CW-1:0]      cnt;

    logic               is_div;
    logic               sgn;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               mbit;
    logic [2*WIDTH-1:0] add_x;
    logic [2*WIDTH-1:0] add_y;
    logic [2*WIDTH-1:0] sum;
    logic               add_sub;

    assign is_div = op_r[1];
    assign sgn    = ~op_r[0];
    assign a_abs  = (sgn && a_r[WIDTH-1]) ? -a_r : a_r;
    assign b_abs  = (sgn && b_r[WIDTH-1]) ? -b_r : b_r;
    assign mbit   = |(b_r & (WIDTH'(1) << cnt));

    // Shared adder operand select.
    always_comb begin
        add_x   = acc;
        add_y   = '0;
        add_sub = 1'b0;
        case (state)
            S_MUL: add_y = {{WIDTH{1'b0}}, a_r} << cnt;
            S_DIV: begin
                // {remainder, next dividend bit} minus divisor; the MSB of
                // the 2W result is the trial sign.
                add_x   = {{(WIDTH-1){1'b0}}, acc[2*WIDTH-1:WIDTH-1]};
                add_y   = {{WIDTH{1'b0}}, b_r};
                add_sub = 1'b1;
            end
            S_FIX: begin
                add_x   = '0;
                add_y   = acc;
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum = add_sub ? (add_x - add_y) : (add_x + add_y);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
        end else if (bus.annul) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    op_r  <= bus.op;
                    a_r   <= bus.src_a;
                    b_r   <= bus.src_b;
                    state <= S_PREP;
                end
                S_PREP: begin
                    a_r   <= a_abs;
                    b_r   <= b_abs;
                    neg_q <= sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r <= sgn & a_r[WIDTH-1];
                    cnt   <= '0;
                    if (!is_div) begin
                        acc   <= '0;
                        state <= (FAST_ZERO != 0 && (a_r == '0 || b_r == '0)) ? S_DONE : S_MUL;
                    end else if (FAST_ZERO != 0 && b_r == '0) begin
                        // Defined divide-by-zero result: raw dividend in HI.
                        acc   <= {a_r, {WIDTH{1'b1}}};
                        state <= S_DONE;
                    end else begin
                        acc   <= {{WIDTH{1'b0}}, a_abs};
                        state <= S_DIV;
                    end
                end
                S_MUL: begin
                    if (mbit) acc <= sum;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_DIV: begin
                    if (!sum[2*WIDTH-1]) acc <= {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else                 acc <= {acc[2*WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    if (!is_div) begin
                        if (neg_q) acc <= sum;
                    end else begin
                        if (neg_q) acc[WIDTH-1:0]       <= -acc[WIDTH-1:0];
                        if (neg_r) acc[2*WIDTH-1:WIDTH] <= -acc[2*WIDTH-1:WIDTH];
                    end
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.done     = (state == S_DONE);
    assign bus.hi_we    = bus.done;
    assign bus.lo_we    = bus.done;
    assign bus.hi_wdata = bus.done ? acc[2*WIDTH-1:WIDTH] : '0;
    assign bus.lo_wdata = bus.done ? acc[WIDTH-1:0]       : '0;
    assign bus.busy     = (state != S_IDLE);
    // The DONE cycle releases the pipeline so it advances with the write.
    assign bus.stallreq = ~bus.annul &
                          ((state == S_IDLE && bus.start) ||
                           (state != S_IDLE && state != S_DONE));
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized + directed bench for muldiv_ctrl (WIDTH=32, FAST_ZERO=1) against
// an arithmetic reference model.
module tb_muldiv_ctrl;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    muldiv_ctrl_if #(.WIDTH(32)) m ();
    muldiv_ctrl #(.WIDTH(32), .FAST_ZERO(1)) dut (.clk(clk), .resetn(resetn), .bus(m.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb); return p; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[1] && (a == 0 || b == 0)) return 2;
        if (o[1] && b == 0) return 2;
        return 35;
    endfunction

    // Issues one op at the next cycle; returns done cycle, result and a
    // count of per-cycle handshake violations (stall/we/data-zero).
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res, output int bad);
        lat = -1; res = '0; bad = 0;
        @(posedge clk); #1;
        m.start = 1'b1; m.op = o; m.src_a = a; m.src_b = b;
        @(negedge clk);
        if (m.stallreq !== 1'b1 || m.done !== 1'b0) bad++;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            m.start = 1'b0; m.op = 2'($urandom); m.src_a = $urandom; m.src_b = $urandom;
            @(negedge clk);
            if (m.done === 1'b1) begin
                lat = c;
                res = {m.hi_wdata, m.lo_wdata};
                if (m.stallreq !== 1'b0 || m.hi_we !== 1'b1 || m.lo_we !== 1'b1) bad++;
                break;
            end else if (m.stallreq !== 1'b1 || m.hi_we !== 1'b0 || m.lo_we !== 1'b0 ||
                         m.hi_wdata !== 32'd0 || m.lo_wdata !== 32'd0 || m.busy !== 1'b1) begin
                bad++;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m.busy, m.done, m.hi_we, m.lo_we, m.stallreq, m.hi_wdata, m.lo_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b stall=%b hi=%h lo=%h want all 0",
                     m.busy, m.done, m.stallreq, m.hi_wdata, m.lo_wdata);
        end
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat, bad; logic [63:0] res, exp;
        exp = model(o, a, b);
        do_op(o, a, b, lat, res, bad);
        checks++;
        if (lat !== exp_lat(o, a, b)) begin
            errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat(o, a, b));
        end
        checks++;
        if (res !== exp) begin
            errors++; $display("FAIL %s result got %h want %h (op=%0d a=%h b=%h)", name, res, exp, o, a, b);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL %s handshake got %0d bad cycles want 0", name, bad);
        end
        @(negedge clk);
        checks++;
        if (m.done !== 1'b0 || m.busy !== 1'b0 || m.hi_we !== 1'b0) begin
            errors++; $display("FAIL %s done_one_cycle got done=%b busy=%b want 0 0", name, m.done, m.busy);
        end
    endtask

    task automatic test_directed;
        run_check("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_check("mult_neg",   2'b00, 32'hFFFFFFFD, 32'h00000005);
        run_check("div_neg",    2'b10, 32'hFFFFFFF9, 32'h00000002);
        run_check("divu_zero",  2'b11, 32'd100,      32'd0);
        run_check("mult_zero",  2'b00, 32'd0,        32'h1234);
        run_check("divu_big",   2'b11, 32'h80000000, 32'd3);
        run_check("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_check("div_zero_s", 2'b10, 32'h80000005, 32'd0);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'd0;
                2: b = 32'($urandom_range(1, 9));
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_check("random", 2'($urandom_range(0, 3)), a, b);
        end
    endtask

    task automatic test_annul;
        int lat, bad, seen; logic [63:0] res;
        seen = 0;
        @(posedge clk); #1;
        m.start = 1'b1; m.op = 2'b00; m.src_a = 32'd7; m.src_b = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            m.start = 1'b0;
            if (c == 10) m.annul = 1'b1;
            @(negedge clk);
            if (m.done || m.hi_we || m.lo_we) seen++;
        end
        checks++;
        if (m.stallreq !== 1'b0) begin
            errors++; $display("FAIL annul_stall got %b want 0", m.stallreq);
        end
        @(posedge clk); #1 m.annul = 1'b0;
        @(negedge clk);
        if (m.done || m.hi_we || m.lo_we) seen++;
        checks++;
        if (m.busy !== 1'b0) begin
            errors++; $display("FAIL annul_idle busy got %b want 0", m.busy);
        end
        do_op(2'b01, 32'd1000, 32'd3000, lat, res, bad);
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL annul_no_write got %0d write cycles want 0", seen);
        end
        checks++;
        if (lat !== 35 || res !== 64'd3000000 || bad != 0) begin
            errors++; $display("FAIL annul_restart got lat=%0d res=%h bad=%0d want 35 %h 0", lat, res, bad, 64'd3000000);
        end
        // annul beats start in IDLE
        @(posedge clk); #1; m.start = 1'b1; m.annul = 1'b1;
        @(negedge clk);
        checks++;
        if (m.stallreq !== 1'b0) begin
            errors++; $display("FAIL annul_vs_start stall got %b want 0", m.stallreq);
        end
        @(posedge clk); #1; m.start = 1'b0; m.annul = 1'b0;
        @(negedge clk);
        checks++;
        if (m.busy !== 1'b0) begin
            errors++; $display("FAIL annul_vs_start busy got %b want 0", m.busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bad, lat2; logic [63:0] res, res2, exp2;
        logic [31:0] a2, b2;
        a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
        exp2 = model(2'b11, a2, b2);
        do_op(2'b00, 32'hFFFFFFF0, 32'd3, lat, res, bad);
        checks++;
        if (lat !== 35 || res !== model(2'b00, 32'hFFFFFFF0, 32'd3) || bad != 0) begin
            errors++; $display("FAIL b2b_first got lat=%0d res=%h bad=%0d", lat, res, bad);
        end
        // Still in the DONE cycle: raise start, which must be ignored now and
        // accepted in the following IDLE cycle.
        m.start = 1'b1; m.op = 2'b11; m.src_a = a2; m.src_b = b2;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m.busy !== 1'b0 || m.stallreq !== 1'b1) begin
            errors++; $display("FAIL b2b_idle got busy=%b stall=%b want 0 1", m.busy, m.stallreq);
        end
        lat2 = -1; res2 = '0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1; m.start = 1'b0; m.src_a = $urandom;
            @(negedge clk);
            if (m.done === 1'b1) begin lat2 = c; res2 = {m.hi_wdata, m.lo_wdata}; break; end
        end
        checks++;
        if (lat2 !== 35 || res2 !== exp2) begin
            errors++; $display("FAIL b2b_second got lat=%0d res=%h want 35 %h", lat2, res2, exp2);
        end
        run_check("b2b_third", 2'b10, 32'hFFFFFF00, 32'd7);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        m.start = 1'b1; m.op = 2'b10; m.src_a = 32'd12345; m.src_b = 32'd11;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1 m.start = 1'b0;
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({m.busy, m.done, m.hi_we, m.lo_we, m.stallreq, m.hi_wdata, m.lo_wdata} !== '0) begin
            errors++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want 0", m.busy, m.done, m.hi_wdata, m.lo_wdata);
        end
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
        run_check("after_reset", 2'b10, 32'd12345, 32'd11);
    endtask

    initial begin
        checks = 0; errors = 0;
        resetn = 1'b0;
        m.start = 1'b0; m.op = 2'b00; m.src_a = '0; m.src_b = '0; m.annul = 1'b0;
        test_reset;
        test_directed;
        test_random;
        test_annul;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
